commit_unit: RTL
================

Name: commit_unit

Overview:
- Sits directly downstream of the reorder buffer.
- Consumes its commit stream and answers each offered entry with a same-cycle acknowledge.
- Non-store results retire into the architectural register file write port.
- Stores are pushed into an in-order store write buffer, which drains to data memory over a req/ack handshake.

Parameters:
- SB_DEPTH, 4, store buffer entries (power of two, ≥2).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- commit_en  in  1  ROB offers a ready head entry.
- commit_arch_reg  in  5  destination architectural register.
- commit_val  in  32  result value, or store data.
- commit_is_store  in  1  entry is a store.
- commit_addr  in  32  store byte address, aligned with the ROB head (from the LSQ address array); ignored for non-stores.
- commit_ack  out  1  combinational; entry accepted this cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- mem_req  out  1  store write request.
- mem_addr  out  32  store address, word aligned (bits [1:0] forced 0).
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory accepted the request this cycle.
- sb_empty  out  1  store buffer empty and no request outstanding (fence/halt use).
- retired_cnt  out  CNT_W  count of acknowledged commits.

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, mem_req=0, mem_addr=0, mem_wdata=0, retired_cnt=0, sb_empty=1. Store buffer pointers cleared; FSM returns to IDLE. Reset mid-drain discards all buffered stores and drops mem_req immediately (asynchronous).
- Acknowledge rule:
  - commit_ack = commit_en && (!commit_is_store || !sb_full).
  - sb_full is based on registered occupancy only. A pop in the same cycle does not free a slot for a push (no same-cycle bypass).
- Non-store retire:
  - On ack with commit_is_store=0, the next cycle drives rf_we=1, rf_waddr=commit_arch_reg, rf_wdata=commit_val.
  - rf_we is a one-cycle pulse per ack.
  - If commit_arch_reg==0, rf_we stays 0 but the entry is still acked and counted.
- Store retire: on ack with commit_is_store=1, {addr,val} is written at the tail; tail wraps modulo SB_DEPTH.
- Occupancy: counter 0..SB_DEPTH.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Full when occupancy==SB_DEPTH; empty when 0.
- Drain FSM (two states):
  - IDLE: if occupancy>0, load mem_addr/mem_wdata from the head entry, set mem_req=1, go to REQ.
  - REQ: mem_req, mem_addr and mem_wdata are held stable until mem_ack. On mem_ack, pop the head (head wraps).
    - If occupancy after the pop is >0, reload from the new head and stay in REQ (back-to-back, no idle cycle).
    - Otherwise set mem_req=0 and return to IDLE.
  - mem_ack while in IDLE is ignored.
- sb_empty = (occupancy==0) && state==IDLE.
- retired_cnt increments by 1 on every cycle with commit_ack=1 and wraps at 2^CNT_W.
- Latency:
  - Non-store ack to rf_we: 1 cycle.
  - Store ack into an empty, idle buffer to mem_req: 2 cycles (push cycle, then IDLE→REQ).

Optional Feature:
- Macro STORE_FWD_EN.
- When defined, adds ports:
  - fwd_addr  in  32
  - fwd_hit  out  1, combinational
  - fwd_data  out  32, combinational
- Lookup compares fwd_addr[31:2] against every valid buffered entry and returns the data of the youngest match (closest to tail). The entry currently being driven on mem_req counts as valid until popped.
- fwd_hit=0 and fwd_data=0 when nothing matches.
- When not defined: no ports and no comparators; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - commit FSM state typedef (IDLE, REQ);
  - store buffer entry struct {addr[31:0], data[31:0]};
  - constant ZERO_REG=5'd0.
- One natural sub-module: store_write_buffer. It contains the FIFO storage, pointers, occupancy, drain FSM and the optional forwarding lookup.
- commit_unit keeps the ack logic, register file write stage and retire counter.

Test Plan:
- Reset, then commit_en=1, is_store=0, reg=5, val=0xDEADBEEF → commit_ack=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; retired_cnt=1.
- Commit to reg=0, val=0x1234 → ack=1, rf_we stays 0, retired_cnt increments.
- Hold mem_ack=0 and offer 5 stores (addr 0x100,0x104,...) → first 4 acked, 5th gets commit_ack=0. mem_req=1 with mem_addr=0x100 held stable throughout.
- Pulse mem_ack for 4 consecutive cycles from a full buffer → mem_addr walks 0x100,0x104,0x108,0x10C with no gap; then mem_req=0 and sb_empty=1.
- Buffer full and mem_ack=1 in the same cycle a store is offered → commit_ack=0 that cycle, acked next cycle; occupancy never exceeds 4.
- Assert rst_n=0 while mem_req=1 with 3 entries buffered → mem_req=0 immediately; after release, sb_empty=1 and no stale request. With STORE_FWD_EN defined, buffer stores 0xA then 0xB to 0x200 and probe fwd_addr=0x202 → fwd_hit=1, fwd_data=0xB.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: drain FSM state, store buffer entry, zero register.
package commit_unit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/commit_unit_store_write_buffer.sv
// In-order store write buffer draining to memory over req/ack; a push reaches mem_req 2 cycles later.
// Pushes are gated upstream by full_o; optional lookup under STORE_FWD_EN.
module store_write_buffer
  import commit_unit_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  sb_entry_t   push_entry_i,
  output logic        full_o,
  output logic        empty_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i
`ifdef STORE_FWD_EN
  ,
  input  logic [31:0] fwd_addr_i,
  output logic        fwd_hit_o,
  output logic [31:0] fwd_data_o
`endif
);

  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SB_DEPTH);

  sb_entry_t          mem_q [SB_DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q, head_nxt;
  logic [OCC_W-1:0]   occ_q, occ_d;
  drain_state_e       state_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q, mem_wdata_q;
  logic               pop;

  assign pop      = (state_q == REQ) && mem_ack_i;
  assign head_nxt = head_q + PTR_W'(1);

  always_comb begin
    occ_d = occ_q;
    if (push_i && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!push_i && pop) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      occ_q <= occ_d;
      if (push_i) tail_q <= tail_q + PTR_W'(1);
      if (pop)    head_q <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (occ_q != '0) begin
            mem_req_q   <= 1'b1;
            mem_addr_q  <= mem_q[head_q].addr;
            mem_wdata_q <= mem_q[head_q].data;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            if (occ_q > OCC_W'(1)) begin
              mem_addr_q  <= mem_q[head_nxt].addr;
              mem_wdata_q <= mem_q[head_nxt].data;
            end else if (push_i) begin
              // The only remaining entry is being written this cycle; take it straight from the push.
              mem_addr_q  <= push_entry_i.addr;
              mem_wdata_q <= push_entry_i.data;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign full_o      = (occ_q == OCC_FULL);
  assign empty_o     = (occ_q == '0) && (state_q == IDLE);
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  logic [1:0]       unused_fwd_lsb;
  assign unused_fwd_lsb = fwd_addr_i[1:0];

  // Scan oldest to youngest so the last hit wins; the entry on mem_req stays valid until popped.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((OCC_W'(i) < occ_q) && (mem_q[fwd_idx].addr[31:2] == fwd_addr_i[31:2])) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = mem_q[fwd_idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/commit_unit.sv
// Commit stage behind the ROB: same-cycle ack, 1-cycle register file write, stores into a drain buffer.
// Stores are refused while the buffer is full; STORE_FWD_EN adds a store-to-load forwarding lookup.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_en,
  input  logic [4:0]       commit_arch_reg,
  input  logic [31:0]      commit_val,
  input  logic             commit_is_store,
  input  logic [31:0]      commit_addr,
  output logic             commit_ack,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  output logic             sb_empty,
  output logic [CNT_W-1:0] retired_cnt
`ifdef STORE_FWD_EN
  ,
  input  logic [31:0]      fwd_addr,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data
`endif
);

  logic             sb_full, sb_push, rf_ack;
  sb_entry_t        sb_entry;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       unused_addr_lsb;

  assign unused_addr_lsb = commit_addr[1:0];

  // sb_full reflects registered occupancy only, so a same-cycle pop never frees a slot.
  assign commit_ack = commit_en && (!commit_is_store || !sb_full);
  assign sb_push    = commit_ack && commit_is_store;
  assign rf_ack     = commit_ack && !commit_is_store;
  assign sb_entry   = '{addr: {commit_addr[31:2], 2'b00}, data: commit_val};

  always_comb begin
    rf_we_d    = rf_ack && (commit_arch_reg != ZERO_REG);
    rf_waddr_d = rf_ack ? commit_arch_reg : rf_waddr_q;
    rf_wdata_d = rf_ack ? commit_val : rf_wdata_q;
    cnt_d      = commit_ack ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign retired_cnt = cnt_q;

  store_write_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_swb (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (sb_push),
    .push_entry_i (sb_entry),
    .full_o       (sb_full),
    .empty_o      (sb_empty),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack)
`ifdef STORE_FWD_EN
    ,
    .fwd_addr_i   (fwd_addr),
    .fwd_hit_o    (fwd_hit),
    .fwd_data_o   (fwd_data)
`endif
  );

endmodule
